// File: rtl/v_decoder_pkg.sv
// Shared types, constants and helpers for the scanning decoder.
//   state_t      : controller states IDLE / DIRECT / SCAN
//   MODE_*       : encodings of the mode input
//   MAX_SEL_W    : widest select the onehot helper supports
//   onehot()     : one-hot (pol=0) or one-cold (pol=1) pattern for an index
package v_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_SEL_W = 5;
    localparam int MAX_OUT_N = 32;

    // Callers narrow the result to their own output count with a size cast.
    function automatic logic [MAX_OUT_N-1:0] onehot(input logic [MAX_SEL_W-1:0] idx,
                                                    input logic                 pol);
        logic [MAX_OUT_N-1:0] hot;
        hot      = {MAX_OUT_N{1'b0}};
        hot[idx] = 1'b1;
        if (pol) begin
            return ~hot;
        end else begin
            return hot;
        end
    endfunction

endpackage

// File: rtl/v_scan_decoder_if.sv
// Control/status bundle of the scanning decoder.
//   master : control logic side (drives en/mode/load/sel/dwell, sees y/idx/wrap)
//   slave  : decoder side
interface v_scan_decoder_if #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 16
) ();
    localparam int OUT_N = 2 ** SEL_W;

    logic               en;
    logic               mode;
    logic               load;
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_N-1:0]   y;
    logic [SEL_W-1:0]   idx;
    logic               wrap;

    modport master (
        output en, mode, load, sel, dwell,
        input  y, idx, wrap
    );

    modport slave (
        input  en, mode, load, sel, dwell,
        output y, idx, wrap
    );
endinterface

// File: rtl/v_onehot_decode.sv
// Combinational SEL_W -> 2**SEL_W decoder with active-low enable (a
// generalised 74x139 half).
//   g_l : 0 = decode sel, 1 = every output inactive
//   sel : index to assert
//   y   : decoded outputs; ACTIVE_LOW selects one-cold (1) or one-hot (0)
module v_onehot_decode
    import v_decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  g_l,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   y
);
    localparam int   OUT_N = 2 ** SEL_W;
    localparam logic POL   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [MAX_SEL_W-1:0] sel_ext_s;

    assign sel_ext_s = MAX_SEL_W'(sel);

    // Decode, or hold every line at its inactive level when disabled.
    always_comb begin
        y = {OUT_N{POL}};
        if (g_l) begin
            y = {OUT_N{POL}};
        end else begin
            y = OUT_N'(onehot(sel_ext_s, POL));
        end
    end
endmodule

// File: rtl/v_scan_decoder.sv
// Parametrised decoder with registered outputs and two modes:
//   DIRECT : decodes a select value captured by load
//   SCAN   : walks the outputs in turn, each held dwell+1 cycles, with BLANK
//            all-inactive cycles inserted after every step
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of v_scan_decoder_if (en/mode/load/sel/dwell in,
//           y/idx/wrap out, all outputs registered)
module v_scan_decoder
    import v_decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int DWELL_W    = 16,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK      = 1
) (
    input  logic           clk,
    input  logic           reset,
    v_scan_decoder_if.slave bus
);
    localparam int         OUT_N      = 2 ** SEL_W;
    localparam logic [1:0] BLANK_INIT = 2'(BLANK);
    localparam logic       POL        = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    state_t             state_r;
    state_t             state_nx_s;
    logic [SEL_W-1:0]   idx_r;
    logic [SEL_W-1:0]   idx_nx_s;
    logic [DWELL_W-1:0] cnt_r;
    logic [DWELL_W-1:0] cnt_nx_s;
    logic [1:0]         blank_r;
    logic [1:0]         blank_nx_s;
    logic               wrap_r;
    logic               wrap_nx_s;
    logic               show_s;
    logic [OUT_N-1:0]   dec_s;
    logic [OUT_N-1:0]   y_r;

    // Next state, next index, dwell/blank counters and whether y shows a decode.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        cnt_nx_s   = cnt_r;
        blank_nx_s = blank_r;
        wrap_nx_s  = 1'b0;
        show_s     = 1'b0;
        if (!bus.en) begin
            // Disable beats any mode; the index survives for the next enable.
            state_nx_s = IDLE;
            cnt_nx_s   = {DWELL_W{1'b0}};
            blank_nx_s = 2'd0;
            show_s     = 1'b0;
        end else begin
            case (bus.mode)
                MODE_DIRECT: begin
                    state_nx_s = DIRECT;
                    cnt_nx_s   = {DWELL_W{1'b0}};
                    blank_nx_s = 2'd0;
                    show_s     = 1'b1;
                    if (bus.load) begin
                        idx_nx_s = bus.sel;
                    end else begin
                        idx_nx_s = idx_r;
                    end
                end
                MODE_SCAN: begin
                    state_nx_s = SCAN;
                    if (state_r != SCAN) begin
                        // Fresh entry: start at the current index, no blank.
                        cnt_nx_s   = {DWELL_W{1'b0}};
                        blank_nx_s = 2'd0;
                        show_s     = 1'b1;
                    end else if (blank_r != 2'd0) begin
                        // Blank cycles do not advance the dwell count.
                        blank_nx_s = blank_r - 2'd1;
                        cnt_nx_s   = {DWELL_W{1'b0}};
                        show_s     = (blank_r == 2'd1);
                    end else if (cnt_r >= bus.dwell) begin
                        // Live compare: lowering dwell mid-count steps at once.
                        cnt_nx_s   = {DWELL_W{1'b0}};
                        idx_nx_s   = idx_r + SEL_W'(1);
                        blank_nx_s = BLANK_INIT;
                        wrap_nx_s  = &idx_r;
                        show_s     = (BLANK_INIT == 2'd0);
                    end else begin
                        cnt_nx_s = cnt_r + DWELL_W'(1);
                        show_s   = 1'b1;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = {DWELL_W{1'b0}};
                    blank_nx_s = 2'd0;
                    show_s     = 1'b0;
                end
            endcase
        end
    end

    // Single decoder instance; it looks at the next index so y lines up with idx.
    v_onehot_decode #(
        .SEL_W      (SEL_W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_decode (
        .g_l (~show_s),
        .sel (idx_nx_s),
        .y   (dec_s)
    );

    // State, counters and all three outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= {SEL_W{1'b0}};
            cnt_r   <= {DWELL_W{1'b0}};
            blank_r <= 2'd0;
            wrap_r  <= 1'b0;
            y_r     <= {OUT_N{POL}};
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            cnt_r   <= cnt_nx_s;
            blank_r <= blank_nx_s;
            wrap_r  <= wrap_nx_s;
            y_r     <= dec_s;
        end
    end

    assign bus.y    = y_r;
    assign bus.idx  = idx_r;
    assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_v_scan_decoder.sv
// Bench for v_scan_decoder: three configurations, a behavioural model per
// configuration feeding per-DUT expectation queues, a negedge monitor that
// pops and compares, plus directed checks of the documented scenarios.
module tb_v_scan_decoder;

    typedef struct {
        bit scanning;
        bit show;
        int idx;
        int vis;
        int blank_left;
        bit wrap;
    } model_t;

    typedef struct {
        logic [7:0] y;
        int         idx;
        logic       wrap;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    exp_t   q_a[$];
    exp_t   q_b[$];
    exp_t   q_c[$];
    model_t ma;
    model_t mb;
    model_t mc;

    v_scan_decoder_if #(.SEL_W(3), .DWELL_W(16)) bus_a ();
    v_scan_decoder_if #(.SEL_W(3), .DWELL_W(16)) bus_b ();
    v_scan_decoder_if #(.SEL_W(2), .DWELL_W(16)) bus_c ();

    assign bus_b.en    = bus_a.en;
    assign bus_b.mode  = bus_a.mode;
    assign bus_b.load  = bus_a.load;
    assign bus_b.sel   = bus_a.sel;
    assign bus_b.dwell = bus_a.dwell;

    v_scan_decoder #(.SEL_W(3), .DWELL_W(16), .ACTIVE_LOW(1), .BLANK(0))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    v_scan_decoder #(.SEL_W(3), .DWELL_W(16), .ACTIVE_LOW(1), .BLANK(1))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    v_scan_decoder #(.SEL_W(2), .DWELL_W(16), .ACTIVE_LOW(0), .BLANK(0))
        dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: visible cycles per index, blank gaps, mode rules.
    function automatic model_t model_step(input model_t m, input bit rst, input bit en,
                                          input bit mode, input bit load, input int sel,
                                          input int dwell, input int n, input int blank);
        model_t r = m;
        r.wrap = 1'b0;
        if (rst) begin
            r.scanning = 1'b0; r.show = 1'b0; r.idx = 0; r.vis = 0; r.blank_left = 0;
        end else if (!en) begin
            r.scanning = 1'b0; r.show = 1'b0;
        end else if (!mode) begin
            r.scanning = 1'b0; r.show = 1'b1;
            if (load) r.idx = sel;
        end else if (!m.scanning) begin
            r.scanning = 1'b1; r.show = 1'b1; r.vis = 1; r.blank_left = 0;
        end else if (m.blank_left > 0) begin
            r.blank_left = m.blank_left - 1;
            if (r.blank_left == 0) begin
                r.show = 1'b1; r.vis = 1;
            end else begin
                r.show = 1'b0;
            end
        end else if (m.vis >= dwell + 1) begin
            r.idx  = (m.idx + 1) % n;
            r.wrap = (r.idx == 0);
            if (blank > 0) begin
                r.blank_left = blank; r.show = 1'b0; r.vis = 0;
            end else begin
                r.show = 1'b1; r.vis = 1;
            end
        end else begin
            r.vis  = m.vis + 1;
            r.show = 1'b1;
        end
        return r;
    endfunction

    function automatic exp_t to_exp(input model_t m, input int n, input bit al);
        exp_t       e;
        logic [7:0] mask;
        logic [7:0] hot;
        mask = 8'((1 << n) - 1);
        hot  = 8'(1 << m.idx);
        if (!m.show) e.y = al ? mask : 8'h00;
        else         e.y = al ? (~hot & mask) : hot;
        e.idx  = m.idx;
        e.wrap = m.wrap;
        return e;
    endfunction

    // Model: advance on every rising edge and queue what the DUTs must show.
    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        mc = '{default: 0};
        forever begin
            @(posedge clk);
            ma = model_step(ma, reset, bus_a.en, bus_a.mode, bus_a.load, int'(bus_a.sel),
                            int'(bus_a.dwell), 8, 0);
            mb = model_step(mb, reset, bus_a.en, bus_a.mode, bus_a.load, int'(bus_a.sel),
                            int'(bus_a.dwell), 8, 1);
            mc = model_step(mc, reset, bus_c.en, bus_c.mode, bus_c.load, int'(bus_c.sel),
                            int'(bus_c.dwell), 4, 0);
            q_a.push_back(to_exp(ma, 8, 1'b1));
            q_b.push_back(to_exp(mb, 8, 1'b1));
            q_c.push_back(to_exp(mc, 4, 1'b0));
        end
    end

    // Monitor: compare registered outputs mid-cycle against the queued model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("sb_a_y", 32'(bus_a.y), 32'(e.y));
                check("sb_a_idx", 32'(bus_a.idx), 32'(e.idx));
                check("sb_a_wrap", 32'(bus_a.wrap), 32'(e.wrap));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("sb_b_y", 32'(bus_b.y), 32'(e.y));
                check("sb_b_idx", 32'(bus_b.idx), 32'(e.idx));
                check("sb_b_wrap", 32'(bus_b.wrap), 32'(e.wrap));
            end
            if (q_c.size() > 0) begin
                e = q_c.pop_front();
                check("sb_c_y", 32'(bus_c.y), 32'(e.y));
                check("sb_c_idx", 32'(bus_c.idx), 32'(e.idx));
                check("sb_c_wrap", 32'(bus_c.wrap), 32'(e.wrap));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Directed scenarios followed by a randomized run.
    initial begin
        int         exp_idx2[9];
        int         e_idx;
        logic [7:0] e_y;
        checks   = 0;
        failures = 0;
        exp_idx2 = '{6, 6, 6, 7, 7, 7, 0, 0, 0};
        reset = 1'b1;
        bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.load = 1'b0; bus_a.sel = 3'd0; bus_a.dwell = 16'd0;
        bus_c.en = 1'b0; bus_c.mode = 1'b0; bus_c.load = 1'b0; bus_c.sel = 2'd0; bus_c.dwell = 16'd0;
        tick(2);
        check("rst_a_y", 32'(bus_a.y), 32'h0000_00FF);
        check("rst_a_idx", 32'(bus_a.idx), 32'd0);
        check("rst_c_y", 32'(bus_c.y), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(1);

        // DIRECT load of 5.
        bus_a.en = 1'b1; bus_a.load = 1'b1; bus_a.sel = 3'd5;
        tick(1);
        check("t1_y", 32'(bus_a.y), 32'h0000_00DF);
        check("t1_idx", 32'(bus_a.idx), 32'd5);
        check("t1_wrap", 32'(bus_a.wrap), 32'd0);
        bus_a.load = 1'b0; bus_a.sel = 3'd1;
        tick(2);
        check("t1_hold_idx", 32'(bus_a.idx), 32'd5);

        // SCAN dwell=2 from 6, wrap on first cycle at 0.
        bus_a.load = 1'b1; bus_a.sel = 3'd6;
        tick(1);
        bus_a.load = 1'b0; bus_a.mode = 1'b1; bus_a.dwell = 16'd2;
        for (int k = 0; k < 9; k++) begin
            tick(1);
            check("t2_idx", 32'(bus_a.idx), 32'(exp_idx2[k]));
            check("t2_wrap", 32'(bus_a.wrap), (k == 6) ? 32'd1 : 32'd0);
        end
        bus_a.load = 1'b1; bus_a.sel = 3'd1;
        tick(3);

        // SCAN dwell=0 with one blank cycle (dut_b).
        bus_a.mode = 1'b0; bus_a.load = 1'b1; bus_a.sel = 3'd2;
        tick(1);
        bus_a.load = 1'b0; bus_a.mode = 1'b1; bus_a.dwell = 16'd0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (k % 2 == 0) begin
                e_idx = 2 + k / 2;
                e_y   = ~(8'd1 << e_idx);
            end else begin
                e_idx = 2 + (k + 1) / 2;
                e_y   = 8'hFF;
            end
            check("t3_y", 32'(bus_b.y), 32'(e_y));
            check("t3_idx", 32'(bus_b.idx), 32'(e_idx));
        end

        // en dropped mid-scan at idx 3, then resumes.
        bus_a.mode = 1'b0; bus_a.load = 1'b1; bus_a.sel = 3'd3;
        tick(1);
        bus_a.load = 1'b0; bus_a.mode = 1'b1; bus_a.dwell = 16'd5;
        tick(3);
        bus_a.en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("t4_off_y", 32'(bus_a.y), 32'h0000_00FF);
            check("t4_off_idx", 32'(bus_a.idx), 32'd3);
        end
        bus_a.en = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            check("t4_resume_idx", 32'(bus_a.idx), (k <= 6) ? 32'd3 : 32'd4);
        end

        // 2-bit active-high decoder: dwell lowered from 9 to 1 at cnt=5.
        bus_c.en = 1'b1; bus_c.mode = 1'b0; bus_c.load = 1'b1; bus_c.sel = 2'd0;
        tick(1);
        check("t6_direct_y", 32'(bus_c.y), 32'd1);
        bus_c.load = 1'b0; bus_c.mode = 1'b1; bus_c.dwell = 16'd9;
        tick(6);
        check("t6_before_y", 32'(bus_c.y), 32'd1);
        check("t6_before_idx", 32'(bus_c.idx), 32'd0);
        bus_c.dwell = 16'd1;
        tick(1);
        check("t6_after_y", 32'(bus_c.y), 32'd2);
        check("t6_after_idx", 32'(bus_c.idx), 32'd1);

        // Randomized traffic on all three decoders.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                bus_a.en    = ($urandom_range(0, 7) != 0);
                bus_a.mode  = ($urandom_range(0, 2) != 0);
                bus_a.dwell = 16'($urandom_range(0, 3));
            end
            bus_a.load = 1'($urandom_range(0, 1));
            bus_a.sel  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) begin
                bus_c.en    = ($urandom_range(0, 7) != 0);
                bus_c.mode  = ($urandom_range(0, 2) != 0);
                bus_c.dwell = 16'($urandom_range(0, 3));
            end
            bus_c.load = 1'($urandom_range(0, 1));
            bus_c.sel  = 2'($urandom_range(0, 3));
            tick(1);
        end

        // Asynchronous reset mid-dwell at idx 4.
        bus_a.en = 1'b1; bus_a.mode = 1'b0; bus_a.load = 1'b1; bus_a.sel = 3'd4;
        tick(1);
        bus_a.load = 1'b0; bus_a.mode = 1'b1; bus_a.dwell = 16'd7;
        tick(4);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t5_y", 32'(bus_a.y), 32'h0000_00FF);
        check("t5_idx", 32'(bus_a.idx), 32'd0);
        check("t5_wrap", 32'(bus_a.wrap), 32'd0);
        check("t5_b_y", 32'(bus_b.y), 32'h0000_00FF);
        tick(1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        tick(30);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
